// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the instruction SRAM port, loads programs
// from the host and streams sequential fetches to the core through a
// 2-entry output buffer with branch redirect.
module instr_fetch_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [ADDR_W:0]   pc_q, pc_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [DATA_W-1:0] buf_data_d [2];
  logic [ADDR_W-1:0] buf_pc_q [2];
  logic [ADDR_W-1:0] buf_pc_d [2];
  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              done_q, done_d;

  logic              wr_en, rd_en, pop, run_end;
  logic [2:0]        occ;
  logic [1:0]        cnt;

  assign pop     = instr_valid & instr_ready;
  // Occupancy the buffer would have next cycle if nothing new were issued.
  assign occ     = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign wr_en   = (state_q == S_LOAD) & load_valid;
  assign rd_en   = (state_q == S_RUN) & (pc_q < prog_len_q) & (occ < 3'd2) & ~branch_valid;
  assign run_end = (state_q == S_RUN) & (pc_q >= prog_len_q) & (count_q == 2'd0) & ~inflight_q;

  // SRAM port decode from registered state (write and read are mutually exclusive by state).
  always_comb begin
    sram_ceb = ~(wr_en | rd_en);
    sram_web = ~wr_en;
    sram_a   = '0;
    sram_d   = '0;
    if (wr_en) begin
      sram_a = wr_ptr_q;
      sram_d = load_data;
    end else if (rd_en) begin
      sram_a = pc_q[ADDR_W-1:0];
    end
  end

  assign load_ready  = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign prog_len    = prog_len_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = buf_data_q[0];
  assign instr_pc    = buf_pc_q[0];

  // Next-state logic for the controller, buffer and fetch pointer.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    prog_len_d    = prog_len_q;
    pc_d          = pc_q;
    buf_data_d    = buf_data_q;
    buf_pc_d      = buf_pc_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    done_d        = 1'b0;
    cnt           = count_q;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end else if (start) begin
          if (prog_len_q != '0) begin
            state_d    = S_RUN;
            pc_d       = '0;
            count_d    = '0;
            inflight_d = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (load_last || (wr_ptr_q == ADDR_W'(DEPTH - 1))) begin
            prog_len_d = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
            state_d    = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (run_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (branch_valid) begin
          count_d    = '0;
          inflight_d = 1'b0;
          pc_d       = {1'b0, branch_addr};
        end else begin
          // Pop shifts the tail to the head first; the returning read then
          // lands in the first free slot, so pop+push in one cycle is seamless.
          if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_pc_d[0]   = buf_pc_q[1];
            cnt           = count_q - 2'd1;
          end
          if (inflight_q) begin
            buf_data_d[cnt[0]] = sram_q;
            buf_pc_d[cnt[0]]   = inflight_pc_q;
            cnt                = cnt + 2'd1;
          end
          count_d       = cnt;
          inflight_d    = rd_en;
          inflight_pc_d = pc_q[ADDR_W-1:0];
          if (rd_en) pc_d = pc_q + (ADDR_W+1)'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      pc_q          <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      prog_len_q    <= prog_len_d;
      pc_q          <= pc_d;
      buf_data_q    <= buf_data_d;
      buf_pc_q      <= buf_pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl with a behavioural SRAM.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0, load_valid = 1'b0, load_last = 1'b0, start = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready, busy, done, instr_valid;
  logic        instr_ready = 1'b0, branch_valid = 1'b0;
  logic [4:0]  branch_addr = '0;
  logic [5:0]  prog_len;
  logic [31:0] instr, sram_d;
  logic [31:0] sram_q = '0;
  logic [4:0]  instr_pc, sram_a;
  logic        sram_ceb, sram_web;

  int n_chk = 0;
  int n_err = 0;

  instr_fetch_ctrl #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start),
    .prog_len(prog_len), .busy(busy), .done(done),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .branch_valid(branch_valid), .branch_addr(branch_addr),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  // SRAM model: 1-cycle registered read, counts writes and reads.
  logic [31:0] mem [32];
  int wr_cnt = 0;
  int rd_cnt = 0;
  initial for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) begin
        mem[sram_a] <= sram_d;
        wr_cnt      <= wr_cnt + 1;
      end else begin
        sram_q <= mem[sram_a];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // Delivery monitor: accepted stream, stall stability, outstanding occupancy.
  logic        mon_en = 1'b0;
  logic [31:0] acc_d [$];
  int          acc_pc [$];
  logic        stall_prev = 1'b0;
  logic [31:0] instr_prev = '0;
  logic [4:0]  pc_prev = '0;
  int          stab_err = 0;
  int          n_iss = 0, n_acc = 0, max_out = 0;
  always @(posedge clk) begin
    if (mon_en) begin
      if (instr_valid && instr_ready) begin
        acc_d.push_back(instr);
        acc_pc.push_back(int'(instr_pc));
      end
      if (stall_prev && !(instr_valid && instr == instr_prev && instr_pc == pc_prev))
        stab_err <= stab_err + 1;
      stall_prev <= instr_valid && !instr_ready;
      instr_prev <= instr;
      pc_prev    <= instr_pc;
      n_iss <= n_iss + int'(!sram_ceb && sram_web);
      n_acc <= n_acc + int'(instr_valid && instr_ready);
      if ((n_iss + int'(!sram_ceb && sram_web)) - (n_acc + int'(instr_valid && instr_ready)) > max_out)
        max_out <= (n_iss + int'(!sram_ceb && sram_web)) - (n_acc + int'(instr_valid && instr_ready));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load n words of base+i; load_last raised on word last_at (-1: never).
  task automatic load_words(input int n, input logic [31:0] base, input int last_at, input bit chk_each);
    load_en = 1'b1;
    step();
    load_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + 32'(i);
      load_last  = (i == last_at);
      if (chk_each) begin
        @(negedge clk);
        chk("wr_ceb", sram_ceb, 0);
        chk("wr_web", sram_web, 0);
        chk("wr_addr", sram_a, i);
        chk("wr_data", sram_d, base + 32'(i));
      end
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  int first_k, done_k, done_cnt, br_head_pc, rd_base, acc_base;

  // Start a run and advance cycle by cycle until done (bounded).
  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic do_run(input int mode, input int br_cycle, input logic [4:0] br_addr);
    int k;
    first_k = -1; done_k = -1; done_cnt = 0; br_head_pc = -1;
    rd_base = rd_cnt; acc_base = acc_d.size();
    start = 1'b1;
    k = 0;
    while (k < 60 && !(done_k > 0 && k >= done_k + 2)) begin
      step();
      k++;
      start        = 1'b0;
      instr_ready  = (mode == 0) ? 1'b1 : (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3));
      branch_valid = (k == br_cycle);
      branch_addr  = br_addr;
      @(negedge clk);
      if (instr_valid && first_k < 0) first_k = k;
      if (k == br_cycle) br_head_pc = instr_valid ? int'(instr_pc) : -1;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
    end
    step();
    instr_ready  = 1'b0;
    branch_valid = 1'b0;
    chk("run_done_once", done_cnt, 1);
  endtask

  task automatic chk_seq(input string tag, input int n, input int pcs [8]);
    chk({tag, "_count"}, acc_d.size() - acc_base, n);
    for (int i = 0; i < n; i++) begin
      if (acc_base + i < acc_d.size()) begin
        chk({tag, "_pc"}, acc_pc[acc_base + i], pcs[i]);
        chk({tag, "_data"}, acc_d[acc_base + i], 32'hA0 + 32'(pcs[i]));
      end
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ceb", sram_ceb, 1);
    chk("rst_web", sram_web, 1);
    chk("rst_busy", busy, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_instr", instr, 0);
    chk("rst_sram_a", sram_a, 0);
    step();
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // 4-word load with load_last
    load_words(4, 32'hA0, 3, 1'b1);
    @(negedge clk);
    chk("load4_busy", busy, 0);
    chk("load4_prog_len", prog_len, 4);
    chk("load4_wr_cnt", wr_cnt, 4);
    for (int i = 0; i < 4; i++) chk("load4_mem", mem[i], 32'hA0 + 32'(i));
    step();

    // Full-throughput run
    do_run(0, -1, 5'd0);
    chk("run0_first_valid", first_k, 3);
    chk("run0_done_cycle", done_k, 8);
    chk("run0_reads", rd_cnt - rd_base, 4);
    chk_seq("run0", 4, '{0, 1, 2, 3, 0, 0, 0, 0});

    // Stalling run
    do_run(1, -1, 5'd0);
    chk("run1_reads", rd_cnt - rd_base, 4);
    chk_seq("run1", 4, '{0, 1, 2, 3, 0, 0, 0, 0});
    chk("run1_stable", stab_err, 0);
    chk("run1_max_outstanding", max_out, 2);

    // Branch back to 1 while pc 2 is at the head
    do_run(0, 5, 5'd1);
    chk("br1_head_pc", br_head_pc, 2);
    chk_seq("br1", 6, '{0, 1, 2, 1, 2, 3, 0, 0});

    // Branch beyond program end
    do_run(0, 5, 5'd6);
    chk("br6_head_pc", br_head_pc, 2);
    chk("br6_reads", rd_cnt - rd_base, 4);
    chk_seq("br6", 3, '{0, 1, 2, 0, 0, 0, 0, 0});

    // 32 words without load_last, then load_valid held one extra cycle
    wr_cnt = wr_cnt;
    load_words(32, 32'hB00, -1, 1'b0);
    load_valid = 1'b1;
    @(negedge clk);
    chk("load32_prog_len", prog_len, 32);
    chk("load32_ready_low", load_ready, 0);
    chk("load32_no_extra_write", sram_ceb, 1);
    chk("load32_mem31", mem[31], 32'hB00 + 32'd31);
    step();
    load_valid = 1'b0;

    // load_en beats start
    rd_base = rd_cnt;
    start   = 1'b1;
    load_en = 1'b1;
    step();
    start   = 1'b0;
    load_en = 1'b0;
    @(negedge clk);
    chk("prio_load_ready", load_ready, 1);
    chk("prio_busy", busy, 1);
    load_valid = 1'b1;
    load_data  = 32'hC0;
    load_last  = 1'b1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    chk("prio_prog_len", prog_len, 1);
    chk("prio_no_reads", rd_cnt - rd_base, 0);
    chk("prio_mem0", mem[0], 32'hC0);
    step();

    // Reset mid-run with one buffered entry and one read in flight
    load_words(4, 32'hA0, 3, 1'b0);
    step();
    mon_en = 1'b0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    step();
    chk("mid_pre_valid", instr_valid, 1);
    chk("mid_pre_pc", instr_pc, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ceb", sram_ceb, 1);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_prog_len", prog_len, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    rst     = 1'b0;
    rd_base = rd_cnt;
    start   = 1'b1;
    step();
    start   = 1'b0;
    @(negedge clk);
    chk("empty_start_done", done, 1);
    chk("empty_start_busy", busy, 0);
    step();
    @(negedge clk);
    chk("empty_start_done_pulse", done, 0);
    chk("empty_start_no_reads", rd_cnt - rd_base, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
